// File: rtl/tdoa_xcorr_pkg.sv
// Shared constants, types and FSM encoding for the TDOA cross-correlator.
package tdoa_xcorr_pkg;

  localparam int NDATA   = 128;
  localparam int MAXLAG  = 16;
  localparam int W       = NDATA - 2 * MAXLAG;
  localparam int SCORE_W = $clog2(W + 1);
  localparam int LAG_W   = $clog2(MAXLAG + 1) + 1;
  localparam int NCH     = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic        [NDATA-1:0]   win_t;
  typedef logic        [SCORE_W-1:0] score_t;
  typedef logic signed [LAG_W-1:0]   lag_t;

endpackage

// File: rtl/tdoa_xcorr_if.sv
// Frame-in / result-out bundle between the sample buffer and the correlator.
interface tdoa_xcorr_if;
  import tdoa_xcorr_pkg::*;

  // start is taken on an edge with ena=1 while idle (including the valid cycle);
  // valid is a one-enabled-cycle pulse marking new lag/score outputs, masked while ena=0.
  logic   ena;
  logic   start;
  win_t   dinRef;
  win_t   dinSigA;
  win_t   dinSigB;
  win_t   dinSigC;
  logic   busy;
  logic   valid;
  lag_t   lagA;
  lag_t   lagB;
  lag_t   lagC;
  score_t scoreA;
  score_t scoreB;
  score_t scoreC;
  state_t dbg_state;

  modport master (
    output ena, start, dinRef, dinSigA, dinSigB, dinSigC,
    input  busy, valid, lagA, lagB, lagC, scoreA, scoreB, scoreC, dbg_state
  );

  modport slave (
    input  ena, start, dinRef, dinSigA, dinSigB, dinSigC,
    output busy, valid, lagA, lagB, lagC, scoreA, scoreB, scoreC, dbg_state
  );

endinterface

// File: rtl/tdoa_xcorr_popcnt.sv
// Single-cycle population count of a match vector.
module tdoa_xcorr_popcnt #(
  parameter int W  = 96,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/tdoa_xcorr.sv
// Latches one frame of 1-bit windows and scans lags -MAXLAG..+MAXLAG, one per cycle,
// keeping the best XNOR-popcount score and its lag for each of channels A/B/C.
module tdoa_xcorr
  import tdoa_xcorr_pkg::*;
(
  input logic         clk,
  input logic         rst,
  tdoa_xcorr_if.slave xc_io
);

  state_t           state_q;
  logic             busy_q;
  logic             valid_q;
  win_t             ref_q;
  win_t             sig_q        [NCH];
  lag_t             lag_q;
  score_t           best_score_q [NCH];
  lag_t             best_lag_q   [NCH];
  score_t           score_out_q  [NCH];
  lag_t             lag_out_q    [NCH];

  win_t             din_sig      [NCH];
  logic [W-1:0]     ref_win;
  logic [W-1:0]     sig_win      [NCH];
  logic [W-1:0]     match_vec    [NCH];
  score_t           score_d      [NCH];
  logic             better_d     [NCH];
  logic [LAG_W-1:0] off_d;
  logic             last_lag;

  assign din_sig[0] = xc_io.dinSigA;
  assign din_sig[1] = xc_io.dinSigB;
  assign din_sig[2] = xc_io.dinSigC;

  // Lag is biased by +MAXLAG so the channel slice offset runs 0..2*MAXLAG with no wrap.
  assign off_d    = LAG_W'(lag_q + lag_t'(MAXLAG));
  assign ref_win  = W'(ref_q >> MAXLAG);
  assign last_lag = (lag_q == lag_t'(MAXLAG));

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    assign sig_win[ch]   = W'(sig_q[ch] >> off_d);
    assign match_vec[ch] = ~(ref_win ^ sig_win[ch]);

    tdoa_xcorr_popcnt #(
      .W  (W),
      .CW (SCORE_W)
    ) u_popcnt (
      .vec_i (match_vec[ch]),
      .cnt_o (score_d[ch])
    );

    // Strict compare: ties keep the earlier (more negative) lag.
    assign better_d[ch] = (score_d[ch] > best_score_q[ch]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ref_q   <= '0;
      lag_q   <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        sig_q[ch]        <= '0;
        best_score_q[ch] <= '0;
        best_lag_q[ch]   <= '0;
        score_out_q[ch]  <= '0;
        lag_out_q[ch]    <= '0;
      end
    end else if (xc_io.ena) begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xc_io.start) begin
            ref_q   <= xc_io.dinRef;
            lag_q   <= lag_t'(-MAXLAG);
            busy_q  <= 1'b1;
            state_q <= SCAN;
            for (int ch = 0; ch < NCH; ch++) begin
              sig_q[ch]        <= din_sig[ch];
              best_score_q[ch] <= '0;
              best_lag_q[ch]   <= lag_t'(-MAXLAG);
            end
          end
        end
        SCAN: begin
          for (int ch = 0; ch < NCH; ch++) begin
            if (better_d[ch]) begin
              best_score_q[ch] <= score_d[ch];
              best_lag_q[ch]   <= lag_q;
            end
          end
          if (last_lag) begin
            // Fold the final lag into the published result on the same edge.
            for (int ch = 0; ch < NCH; ch++) begin
              score_out_q[ch] <= better_d[ch] ? score_d[ch] : best_score_q[ch];
              lag_out_q[ch]   <= better_d[ch] ? lag_q       : best_lag_q[ch];
            end
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            lag_q <= lag_q + lag_t'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign xc_io.busy      = busy_q;
  assign xc_io.valid     = valid_q & xc_io.ena;
  assign xc_io.lagA      = lag_out_q[0];
  assign xc_io.lagB      = lag_out_q[1];
  assign xc_io.lagC      = lag_out_q[2];
  assign xc_io.scoreA    = score_out_q[0];
  assign xc_io.scoreB    = score_out_q[1];
  assign xc_io.scoreC    = score_out_q[2];
  assign xc_io.dbg_state = state_q;

endmodule

// File: tb/tb_tdoa_xcorr.sv
// Randomised and directed checks of tdoa_xcorr against a brute-force lag-search model.
module tb_tdoa_xcorr;
  import tdoa_xcorr_pkg::*;

  localparam int RES_W = 3 * (LAG_W + SCORE_W);

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [RES_W-1:0] exp_q[$];

  tdoa_xcorr_if xc_if ();

  tdoa_xcorr dut (
    .clk   (clk),
    .rst   (rst),
    .xc_io (xc_if.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exhaustive search over all lags, straight from the scoring rule.
  function automatic logic [LAG_W+SCORE_W-1:0] model_ch(input win_t r, input win_t s);
    int best;
    int best_lag;
    int cnt;
    best     = 0;
    best_lag = -MAXLAG;
    for (int lag = -MAXLAG; lag <= MAXLAG; lag++) begin
      cnt = 0;
      for (int i = MAXLAG; i <= NDATA - 1 - MAXLAG; i++) begin
        if (r[i] == s[i + lag]) cnt++;
      end
      if (cnt > best) begin
        best     = cnt;
        best_lag = lag;
      end
    end
    return {LAG_W'(best_lag), SCORE_W'(best)};
  endfunction

  function automatic win_t rand_win();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Positive lag: channel hears the same pattern later (shifted toward newer bits).
  function automatic win_t shifted(input win_t r, input int lag);
    win_t s;
    if (lag >= 0) s = (r << lag) | (rand_win() & ((win_t'(1) << lag) - win_t'(1)));
    else          s = r >> (-lag);
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_windows(input win_t r, input win_t a, input win_t b, input win_t c);
    xc_if.dinRef  = r;
    xc_if.dinSigA = a;
    xc_if.dinSigB = b;
    xc_if.dinSigC = c;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch();
    exp_q.push_back({model_ch(xc_if.dinRef, xc_if.dinSigA),
                     model_ch(xc_if.dinRef, xc_if.dinSigB),
                     model_ch(xc_if.dinRef, xc_if.dinSigC)});
    xc_if.start = 1'b1;
    @(negedge clk);
    xc_if.start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (xc_if.valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (xc_if.valid !== 1'b1) begin
      check("valid_timeout", 64'd0, 64'd1);
      n = -1;
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (xc_if.valid === 1'b1) cnt++;
    end
  endtask

  task automatic check_result(input string tag);
    logic [RES_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_lagA"},   {xc_if.lagA},   e[3*(LAG_W+SCORE_W)-1 -: LAG_W]);
    check({tag, "_scoreA"}, {xc_if.scoreA}, e[2*(LAG_W+SCORE_W)+SCORE_W-1 -: SCORE_W]);
    check({tag, "_lagB"},   {xc_if.lagB},   e[2*(LAG_W+SCORE_W)-1 -: LAG_W]);
    check({tag, "_scoreB"}, {xc_if.scoreB}, e[(LAG_W+SCORE_W)+SCORE_W-1 -: SCORE_W]);
    check({tag, "_lagC"},   {xc_if.lagC},   e[(LAG_W+SCORE_W)-1 -: LAG_W]);
    check({tag, "_scoreC"}, {xc_if.scoreC}, e[SCORE_W-1:0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int cnt;
    win_t r;
    logic [3*LAG_W-1:0]   exp_lags;
    logic [3*SCORE_W-1:0] exp_scores;

    exp_scores = {SCORE_W'(W), SCORE_W'(W), SCORE_W'(W)};

    // Reset with random inputs.
    rst         = 1'b1;
    xc_if.ena   = 1'b1;
    xc_if.start = 1'(($urandom_range(0, 1)));
    set_windows(rand_win(), rand_win(), rand_win(), rand_win());
    repeat (3) @(negedge clk);
    check("rst_busy",   {xc_if.busy}, 64'd0);
    check("rst_valid",  {xc_if.valid}, 64'd0);
    check("rst_lags",   {xc_if.lagA, xc_if.lagB, xc_if.lagC}, 64'd0);
    check("rst_scores", {xc_if.scoreA, xc_if.scoreB, xc_if.scoreC}, 64'd0);
    check("rst_state",  {xc_if.dbg_state}, {IDLE});
    xc_if.start = 1'b0;
    rst         = 1'b0;
    count_valid(50, cnt);
    check("idle_no_valid", cnt, 64'd0);

    // Identical windows: zero lag, full score.
    r = rand_win();
    set_windows(r, r, r, r);
    launch();
    wait_valid(100, n);
    check("same_latency", n, 64'd33);
    check("same_lags",   {xc_if.lagA, xc_if.lagB, xc_if.lagC}, 64'd0);
    check("same_scores", {xc_if.scoreA, xc_if.scoreB, xc_if.scoreC}, exp_scores);
    check_result("same");

    // Known shifts.
    r = rand_win();
    set_windows(r, shifted(r, 5), shifted(r, -7), shifted(r, 16));
    launch();
    wait_valid(100, n);
    check("shift_latency", n, 64'd33);
    exp_lags = {LAG_W'(5), LAG_W'(-7), LAG_W'(16)};
    check("shift_lags",   {xc_if.lagA, xc_if.lagB, xc_if.lagC}, exp_lags);
    check("shift_scores", {xc_if.scoreA, xc_if.scoreB, xc_if.scoreC}, exp_scores);
    check_result("shift");

    // All-zero windows tie at every lag: earliest lag wins.
    set_windows('0, '0, '0, '0);
    launch();
    wait_valid(100, n);
    exp_lags = {LAG_W'(-MAXLAG), LAG_W'(-MAXLAG), LAG_W'(-MAXLAG)};
    check("zero_lags",   {xc_if.lagA, xc_if.lagB, xc_if.lagC}, exp_lags);
    check("zero_scores", {xc_if.scoreA, xc_if.scoreB, xc_if.scoreC}, exp_scores);
    check_result("zero");

    // Mid-scan stall of 10 cycles plus a start pulse that must be ignored.
    r = rand_win();
    set_windows(r, shifted(r, -3), shifted(r, 11), shifted(r, -16));
    launch();
    repeat (10) @(negedge clk);
    xc_if.ena = 1'b0;
    count_valid(10, cnt);
    check("stall_no_valid", cnt, 64'd0);
    check("stall_busy", {xc_if.busy}, 64'd1);
    xc_if.ena   = 1'b1;
    xc_if.start = 1'b1;
    @(negedge clk);
    xc_if.start = 1'b0;
    wait_valid(100, n);
    check("stall_latency", 21 + n, 64'd43);
    check_result("stall");
    count_valid(40, cnt);
    check("ignored_start_no_valid", cnt, 64'd0);
    check("ignored_start_busy", {xc_if.busy}, 64'd0);

    // Stall exactly on the valid cycle: pulse is held back, then re-asserted.
    r = rand_win();
    set_windows(r, rand_win(), shifted(r, 2), shifted(r, -9));
    launch();
    wait_valid(100, n);
    xc_if.ena = 1'b0;
    #1;
    check("pend_masked", {xc_if.valid}, 64'd0);
    count_valid(3, cnt);
    check("pend_no_valid", cnt, 64'd0);
    xc_if.ena = 1'b1;
    #1;
    check("pend_reassert", {xc_if.valid}, 64'd1);
    check_result("pend");
    @(negedge clk);
    check("pend_one_cycle", {xc_if.valid}, 64'd0);

    // Reset around cycle 12 of a scan: outputs clear at once, no valid follows.
    r = rand_win();
    set_windows(r, shifted(r, 1), shifted(r, 1), shifted(r, 1));
    launch();
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_lags",   {xc_if.lagA, xc_if.lagB, xc_if.lagC}, 64'd0);
    check("abort_scores", {xc_if.scoreA, xc_if.scoreB, xc_if.scoreC}, 64'd0);
    check("abort_busy",   {xc_if.busy}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    count_valid(50, cnt);
    check("abort_no_valid", cnt, 64'd0);

    // Fresh frame, then back-to-back start on the valid cycle.
    r = rand_win();
    set_windows(r, shifted(r, 8), shifted(r, -12), shifted(r, 0));
    launch();
    wait_valid(100, n);
    check("fresh_latency", n, 64'd33);
    check_result("fresh");
    r = rand_win();
    set_windows(r, shifted(r, -1), shifted(r, 14), shifted(r, -5));
    launch();
    wait_valid(100, n);
    check("b2b_latency", n, 64'd33);
    check_result("b2b");

    // Randomised frames with noise.
    for (int k = 0; k < 8; k++) begin
      r = rand_win();
      set_windows(r,
                  shifted(r, $urandom_range(0, 2 * MAXLAG) - MAXLAG) ^ (rand_win() & rand_win() & rand_win()),
                  shifted(r, $urandom_range(0, 2 * MAXLAG) - MAXLAG) ^ (rand_win() & rand_win()),
                  (k % 3 == 0) ? rand_win() : shifted(r, $urandom_range(0, 2 * MAXLAG) - MAXLAG));
      launch();
      wait_valid(100, n);
      check("rand_latency", n, 64'd33);
      check_result("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
